// File: rtl/axis_pkt_mux_n_1_if.sv
// Purpose : AXI-Stream bundle shared by the packet mux input and output sides.
//           NCH lanes of tdata/tvalid/tlast/tready; the output side uses NCH=1.
// Ports   : master drives tdata/tvalid/tlast and samples tready;
//           slave samples tdata/tvalid/tlast and drives tready.
interface axis_pkt_mux_n_1_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned NCH = 1
);
  logic [NCH*DW-1:0] tdata;
  logic [NCH-1:0]    tvalid;
  logic [NCH-1:0]    tlast;
  logic [NCH-1:0]    tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_mux_n_1.sv
// Purpose : Packet-aware N:1 AXI-Stream mux. Locks onto one channel for a whole
//           packet (released on the accepted tlast beat) and feeds a 2-entry
//           main+skid output stage giving 1 beat/clk with no combinational
//           path from m.tready to s.tready.
// Ports   : clk, rst_n (async, active-low)
//           sel     requested channel (fixed-select build only)
//           s       slave bundle, NCH lanes, channel i at tdata[i*DW +: DW]
//           m       master bundle, single lane
//           busy    high while a packet is locked
//           cur_ch  currently / most recently granted channel
// Config  : define RR_ARB_EN for round-robin arbitration; default is fixed select.
module axis_pkt_mux_n_1 #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SELW-1:0] sel,
  axis_pkt_mux_n_1_if.slave  s,
  axis_pkt_mux_n_1_if.master m,
  output logic            busy,
  output logic [SELW-1:0] cur_ch
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e          state_q;
  logic            busy_q;
  logic [SELW-1:0] cur_ch_q;
  logic            m_valid_q;
  logic            m_last_q;
  logic [DW-1:0]   m_data_q;
  logic            skid_valid_q;
  logic            skid_last_q;
  logic [DW-1:0]   skid_data_q;

  logic            in_valid_c;
  logic            in_last_c;
  logic [DW-1:0]   in_data_c;
  logic            accept_c;
  logic            drain_c;
  logic            grant_c;
  logic [SELW-1:0] grant_ch_d;

  // Beat presented by the locked channel
  always_comb begin
    in_valid_c = 1'b0;
    in_last_c  = 1'b0;
    in_data_c  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cur_ch_q == SELW'(i)) begin
        in_valid_c = s.tvalid[i];
        in_last_c  = s.tlast[i];
        in_data_c  = s.tdata[i*DW +: DW];
      end
    end
  end

  // Ready depends only on flops: locked channel, open while skid is empty
  always_comb begin
    s.tready = '0;
    if (state_q == LOCKED && !skid_valid_q) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        s.tready[i] = (cur_ch_q == SELW'(i));
      end
    end
  end

  assign accept_c = (state_q == LOCKED) && !skid_valid_q && in_valid_c;
  assign drain_c  = m_valid_q && m.tready[0];

`ifdef RR_ARB_EN
  logic [SELW-1:0] last_grant_q;
  logic            unused_sel;

  assign unused_sel = ^sel;

  // First valid channel after the last grant, wrapping modulo NCH
  always_comb begin
    grant_c    = 1'b0;
    grant_ch_d = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!grant_c && s.tvalid[i] && (i == (32'(last_grant_q) + k) % NCH)) begin
          grant_c    = 1'b1;
          grant_ch_d = SELW'(i);
        end
      end
    end
  end
`else
  // Fixed select: out-of-range sel matches no channel and never grants
  always_comb begin
    grant_c    = 1'b0;
    grant_ch_d = sel;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel == SELW'(i) && s.tvalid[i]) begin
        grant_c = 1'b1;
      end
    end
  end
`endif

  // Lock FSM and main+skid output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      cur_ch_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
`ifdef RR_ARB_EN
      last_grant_q <= SELW'(NCH - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_c) begin
            state_q  <= LOCKED;
            busy_q   <= 1'b1;
            cur_ch_q <= grant_ch_d;
          end
        end
        LOCKED: begin
          if (accept_c && in_last_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
`ifdef RR_ARB_EN
            last_grant_q <= cur_ch_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase

      // Main refills when empty or draining: skid first, then a new beat
      if (drain_c || !m_valid_q) begin
        if (skid_valid_q) begin
          m_valid_q    <= 1'b1;
          m_data_q     <= skid_data_q;
          m_last_q     <= skid_last_q;
          skid_valid_q <= 1'b0;
        end else if (accept_c) begin
          m_valid_q <= 1'b1;
          m_data_q  <= in_data_c;
          m_last_q  <= in_last_c;
        end else begin
          m_valid_q <= 1'b0;
        end
      end else if (accept_c) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= in_data_c;
        skid_last_q  <= in_last_c;
      end
    end
  end

  assign m.tdata     = m_data_q;
  assign m.tvalid[0] = m_valid_q;
  assign m.tlast[0]  = m_last_q;
  assign busy        = busy_q;
  assign cur_ch      = cur_ch_q;

endmodule

// File: tb/tb_axis_pkt_mux_n_1.sv
// Purpose : Bench for axis_pkt_mux_n_1. A queue-level model (lock state plus a
//           list of at most two in-flight beats) predicts every output each
//           cycle; directed packets pin the model with literal expectations,
//           then randomized packets/valids/readies run against it.
// Config  : honours RR_ARB_EN the same way as the design.
module tb_axis_pkt_mux_n_1;
  localparam int unsigned DW   = 8;
  localparam int unsigned NCH  = 4;
  localparam int unsigned SELW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [SELW-1:0] sel;
  logic            busy;
  logic [SELW-1:0] cur_ch;

  always #5 clk = ~clk;

  axis_pkt_mux_n_1_if #(.DW(DW), .NCH(NCH)) s_if ();
  axis_pkt_mux_n_1_if #(.DW(DW), .NCH(1))   m_if ();

  axis_pkt_mux_n_1 #(.DW(DW), .NCH(NCH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (sel),
    .s      (s_if),
    .m      (m_if),
    .busy   (busy),
    .cur_ch (cur_ch)
  );

  int total;
  int bad;

  // Model: producers, lock, in-flight beats ({last,data})
  logic [8:0] prod_q [NCH][$];
  logic [8:0] fifo [$];
  logic [8:0] last_main;
  bit         locked;
  int         cur;
  int         last_grant;
  bit         accepted [NCH];
  int         seqn [NCH];

  int  vprob;
  bit  mr_rand;
  int  rprob;
  bit  mr_val;
  bit  sel_rand;
  bit  log_en;
  logic [8:0] out_log [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo.delete();
    last_main  = '0;
    locked     = 1'b0;
    cur        = 0;
    last_grant = NCH - 1;
    for (int c = 0; c < NCH; c++) accepted[c] = 1'b0;
  endtask

  function automatic logic [NCH-1:0] exp_tready();
    if (locked && fifo.size() < 2) return NCH'(1 << cur);
    return '0;
  endfunction

  task automatic compare_all();
    logic [8:0] head;
    head = (fifo.size() > 0) ? fifo[0] : last_main;
    check("s_tready", 32'(s_if.tready), 32'(exp_tready()));
    check("m_tvalid", 32'(m_if.tvalid[0]), 32'(fifo.size() > 0));
    check("m_tdata", 32'(m_if.tdata), 32'(head[7:0]));
    check("m_tlast", 32'(m_if.tlast[0]), 32'(head[8]));
    check("busy", 32'(busy), 32'(locked));
    check("cur_ch", 32'(cur_ch), 32'(cur));
  endtask

  task automatic model_update();
    int  n;
    bit  acc;
    bit  found;
    logic [8:0] beat;
    n = fifo.size();
    for (int c = 0; c < NCH; c++) accepted[c] = 1'b0;
    acc = locked && (n < 2) && s_if.tvalid[cur];
    if (n > 0 && m_if.tready[0]) last_main = fifo.pop_front();
    if (acc) begin
      beat = {s_if.tlast[cur], s_if.tdata[cur*DW +: DW]};
      fifo.push_back(beat);
      accepted[cur] = 1'b1;
      if (prod_q[cur].size() > 0) void'(prod_q[cur].pop_front());
      if (beat[8]) begin
        locked     = 1'b0;
        last_grant = cur;
      end
    end else if (!locked) begin
      found = 1'b0;
`ifdef RR_ARB_EN
      for (int k = 1; k <= NCH; k++) begin
        if (!found && s_if.tvalid[(last_grant + k) % NCH]) begin
          found = 1'b1;
          cur   = (last_grant + k) % NCH;
        end
      end
`else
      if (int'(sel) < NCH && s_if.tvalid[sel]) begin
        found = 1'b1;
        cur   = int'(sel);
      end
`endif
      if (found) locked = 1'b1;
    end
  endtask

  task automatic drive();
    logic [8:0] b;
    for (int c = 0; c < NCH; c++) begin
      if (prod_q[c].size() > 0) begin
        b = prod_q[c][0];
        // A presented beat stays valid until it is taken
        if (!(s_if.tvalid[c] && !accepted[c]))
          s_if.tvalid[c] = (int'($urandom_range(99)) < vprob);
        s_if.tdata[c*DW +: DW] = b[7:0];
        s_if.tlast[c]          = b[8];
      end else begin
        s_if.tvalid[c]         = 1'b0;
        s_if.tdata[c*DW +: DW] = 8'($urandom);
        s_if.tlast[c]          = 1'($urandom);
      end
    end
    m_if.tready[0] = mr_rand ? (int'($urandom_range(99)) < rprob) : mr_val;
    if (sel_rand) sel = SELW'($urandom_range(NCH - 1));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    drive();
    @(negedge clk);
    compare_all();
    if (log_en && m_if.tvalid[0] && m_if.tready[0])
      out_log.push_back({m_if.tlast[0], m_if.tdata});
  endtask

  function automatic bit all_done();
    for (int c = 0; c < NCH; c++) if (prod_q[c].size() > 0) return 1'b0;
    return (fifo.size() == 0) && !locked;
  endfunction

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      step();
      n++;
    end
    if (!all_done()) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic push_pkt(input int c, input int len);
    for (int i = 0; i < len; i++) begin
      prod_q[c].push_back({(i == len - 1), 8'({2'(c), 6'(seqn[c])})});
      seqn[c]++;
    end
  endtask

  task automatic check_log(input string nm, input logic [8:0] exp [$]);
    check({nm, "_count"}, 32'(out_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < out_log.size(); i++)
      check(nm, 32'(out_log[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [8:0] exp_log [$];
    total = 0; bad = 0;
    vprob = 100; mr_rand = 1'b0; rprob = 100; mr_val = 1'b1;
    sel_rand = 1'b0; log_en = 1'b0; sel = '0;
    for (int c = 0; c < NCH; c++) seqn[c] = 0;
    s_if.tvalid = '0; s_if.tdata = '0; s_if.tlast = '0; m_if.tready = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_m_tvalid", 32'(m_if.tvalid[0]), 32'h0);
    check("rst_m_tdata", 32'(m_if.tdata), 32'h0);
    check("rst_s_tready", 32'(s_if.tready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cur_ch", 32'(cur_ch), 32'h0);
    rst_n = 1'b1;

    // 3-beat packet on ch2, sel=2, full-speed sink
    sel = 2'd2; mr_val = 1'b1;
    prod_q[2].push_back(9'h0A0); prod_q[2].push_back(9'h0A1); prod_q[2].push_back(9'h1A2);
    step(); check("t1_busy_pre", 32'(busy), 32'h0);
    step(); check("t1_busy", 32'(busy), 32'h1);
            check("t1_cur_ch", 32'(cur_ch), 32'h2);
            check("t1_tready", 32'(s_if.tready), 32'h4);
    step(); check("t1_valid0", 32'(m_if.tvalid[0]), 32'h1);
            check("t1_data0", 32'(m_if.tdata), 32'hA0);
    step(); check("t1_data1", 32'(m_if.tdata), 32'hA1);
    step(); check("t1_data2", 32'(m_if.tdata), 32'hA2);
            check("t1_last2", 32'(m_if.tlast[0]), 32'h1);
            check("t1_busy_end", 32'(busy), 32'h0);
    step(); check("t1_valid_end", 32'(m_if.tvalid[0]), 32'h0);
            check("t1_hold", 32'(m_if.tdata), 32'hA2);
    run_drain(50);

`ifndef RR_ARB_EN
    // sel moves 2->1 after the first ch2 beat; lock must hold to tlast
    out_log.delete(); log_en = 1'b1;
    prod_q[2].push_back(9'h0B0); prod_q[2].push_back(9'h0B1);
    prod_q[2].push_back(9'h0B2); prod_q[2].push_back(9'h1B3);
    prod_q[1].push_back(9'h1C0);
    step(); step(); step();
    sel = 2'd1;
    run_drain(50);
    log_en = 1'b0;
    exp_log = '{9'h0B0, 9'h0B1, 9'h0B2, 9'h1B3, 9'h1C0};
    check_log("t2_order", exp_log);
`endif

    // Back-pressure on a 6-beat ch0 packet
    out_log.delete(); log_en = 1'b1; sel = 2'd0; mr_val = 1'b0;
    for (int i = 0; i < 6; i++) prod_q[0].push_back({(i == 5), 8'(8'hD0 + i)});
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      check("t4_tready_full", 32'(s_if.tready), 32'h0);
      check("t4_valid_held", 32'(m_if.tvalid[0]), 32'h1);
      check("t4_data_held", 32'(m_if.tdata), 32'hD0);
      if (i < 3) step();
    end
    mr_val = 1'b1;
    run_drain(50);
    log_en = 1'b0;
    exp_log.delete();
    for (int i = 0; i < 6; i++) exp_log.push_back({(i == 5), 8'(8'hD0 + i)});
    check_log("t4_order", exp_log);

    // Async reset mid-packet with two beats buffered
    mr_val = 1'b0;
    for (int i = 0; i < 6; i++) prod_q[0].push_back({(i == 5), 8'(8'h60 + i)});
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check("t5_m_tvalid", 32'(m_if.tvalid[0]), 32'h0);
    check("t5_s_tready", 32'(s_if.tready), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    for (int c = 0; c < NCH; c++) prod_q[c].delete();
    s_if.tvalid = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_log.delete(); log_en = 1'b1; mr_val = 1'b1; sel = 2'd1;
    prod_q[1].push_back(9'h1E0);
    step(); check("t5_busy_pre", 32'(busy), 32'h0);
    step(); check("t5_busy", 32'(busy), 32'h1);
            check("t5_cur_ch", 32'(cur_ch), 32'h1);
    run_drain(50);
    log_en = 1'b0;
    exp_log = '{9'h1E0};
    check_log("t5_order", exp_log);

    // Randomized packets, valids, readies and sel
    sel_rand = 1'b1; mr_rand = 1'b1;
    for (int r = 0; r < 4; r++) begin
      vprob = 30 + 20 * r;
      rprob = 100 - 25 * r;
      for (int p = 0; p < 3; p++)
        for (int c = 0; c < NCH; c++) push_pkt(c, 1 + int'($urandom_range(5)));
      run_drain(4000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
